// File: rtl/mux_tree_pipe_pkg.sv
// Shared constants, sizing helpers and the per-stage sideband record for mux_tree_pipe.
package mux_tree_pkg;

    // Sideband fields are sized for the widest supported configuration; narrower builds zero-extend.
    localparam int SIDE_TAG_MAX = 32;
    localparam int SIDE_SEL_MAX = 32;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int calc_levels(input int num_inputs, input int radix_log);
        return ceil_div(clog2(num_inputs), radix_log);
    endfunction

    function automatic int calc_padded(input int num_inputs, input int radix_log);
        return 1 << (calc_levels(num_inputs, radix_log) * radix_log);
    endfunction

    typedef struct packed {
        logic                    valid;
        logic                    oor;
        logic [SIDE_TAG_MAX-1:0] tag;
        logic [SIDE_SEL_MAX-1:0] sel;
    } side_t;

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Valid/ready bus of mux_tree_pipe; o_zero exists only when MUX_TREE_ZERO_FLAG_EN is defined.
interface mux_tree_pipe_if #(
    parameter int BIT_WIDTH  = 16,
    parameter int NUM_INPUTS = 81,
    parameter int TAG_WIDTH  = 8
);
    localparam int SEL_WIDTH = mux_tree_pkg::clog2(NUM_INPUTS);

    logic                            i_valid;
    logic                            o_ready;
    logic [SEL_WIDTH-1:0]            i_sel;
    logic [NUM_INPUTS*BIT_WIDTH-1:0] i_A;
    logic [TAG_WIDTH-1:0]            i_tag;
    logic                            o_valid;
    logic                            i_ready;
    logic [BIT_WIDTH-1:0]            o_B;
    logic [TAG_WIDTH-1:0]            o_tag;
    logic                            o_oor;
`ifdef MUX_TREE_ZERO_FLAG_EN
    logic                            o_zero;

    modport master (output i_valid, i_sel, i_A, i_tag, i_ready,
                    input  o_ready, o_valid, o_B, o_tag, o_oor, o_zero);
    modport slave  (input  i_valid, i_sel, i_A, i_tag, i_ready,
                    output o_ready, o_valid, o_B, o_tag, o_oor, o_zero);
`else
    modport master (output i_valid, i_sel, i_A, i_tag, i_ready,
                    input  o_ready, o_valid, o_B, o_tag, o_oor);
    modport slave  (input  i_valid, i_sel, i_A, i_tag, i_ready,
                    output o_ready, o_valid, o_B, o_tag, o_oor);
`endif
endinterface

// File: rtl/mux_tree_pipe_level.sv
// One registered tree level: NUM_GROUPS independent 2^RADIX_LOG:1 muxes sharing one select.
module mux_tree_level
    import mux_tree_pkg::*;
#(
    parameter int NUM_GROUPS = 1,
    parameter int RADIX_LOG  = 4,
    parameter int BIT_WIDTH  = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          advance,
    input  logic [NUM_GROUPS*(2**RADIX_LOG)*BIT_WIDTH-1:0] data_in,
    input  side_t                                         side_in,
    output logic [NUM_GROUPS*BIT_WIDTH-1:0]                data_q,
    output side_t                                         side_q
);
    localparam int RADIX = 1 << RADIX_LOG;

    logic [RADIX_LOG-1:0]            sel;
    logic [NUM_GROUPS*BIT_WIDTH-1:0] mux_out;
    side_t                           side_next;

    assign sel = side_in.sel[RADIX_LOG-1:0];

    always_comb begin
        mux_out = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            mux_out[g*BIT_WIDTH +: BIT_WIDTH] = data_in[(g*RADIX + int'(sel))*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    // Consumed select bits are shifted out so the next level always reads the low bits.
    always_comb begin
        side_next     = side_in;
        side_next.sel = side_in.sel >> RADIX_LOG;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            side_q <= '0;
        end else if (advance) begin
            data_q <= mux_out;
            side_q <= side_next;
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N-to-1 select tree with a single global stall; MUX_TREE_ZERO_FLAG_EN adds a registered o_zero.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int NUM_INPUTS = 81,
    parameter int RADIX_LOG  = 4,
    parameter int TAG_WIDTH  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_tree_pipe_if.slave bus
);
    localparam int SEL_WIDTH = clog2(NUM_INPUTS);
    localparam int LEVELS    = calc_levels(NUM_INPUTS, RADIX_LOG);
    localparam int PADDED    = calc_padded(NUM_INPUTS, RADIX_LOG);

    logic                        advance;
    logic                        oor;
    logic [PADDED*BIT_WIDTH-1:0] level0_data;
    side_t                       level0_side;
    side_t                       final_side;
    logic [BIT_WIDTH-1:0]        final_data;
    logic                        unused_side;

    assign advance = bus.i_ready | ~final_side.valid;
    assign oor     = {1'b0, bus.i_sel} >= (SEL_WIDTH+1)'(NUM_INPUTS);

    // Out-of-range selects see an all-zero array, so the result is 0 without a late override.
    always_comb begin
        level0_data = '0;
        if (!oor) begin
            level0_data[NUM_INPUTS*BIT_WIDTH-1:0] = bus.i_A;
        end
    end

    always_comb begin
        level0_side                      = '0;
        level0_side.valid                = bus.i_valid;
        level0_side.oor                  = oor;
        level0_side.tag[TAG_WIDTH-1:0]   = bus.i_tag;
        level0_side.sel[SEL_WIDTH-1:0]   = bus.i_sel;
    end

`ifdef MUX_TREE_ZERO_FLAG_EN
    logic zero_next;
    logic zero_q;
`endif

    for (genvar L = 0; L < LEVELS; L++) begin : g_level
        localparam int GROUPS = PADDED >> ((L + 1) * RADIX_LOG);

        logic [GROUPS*(2**RADIX_LOG)*BIT_WIDTH-1:0] data_in;
        side_t                                      side_in;
        logic [GROUPS*BIT_WIDTH-1:0]                data_q;
        side_t                                      side_q;

        if (L == 0) begin : g_first
            assign data_in = level0_data;
            assign side_in = level0_side;
        end else begin : g_next
            assign data_in = g_level[L-1].data_q;
            assign side_in = g_level[L-1].side_q;
        end

`ifdef MUX_TREE_ZERO_FLAG_EN
        // The last level's mux result is what o_B will load, so its zero test lands in the same cycle.
        if (L == LEVELS - 1) begin : g_zero
            assign zero_next = (data_in[int'(side_in.sel[RADIX_LOG-1:0])*BIT_WIDTH +: BIT_WIDTH] == '0);
        end
`endif

        mux_tree_level #(
            .NUM_GROUPS (GROUPS),
            .RADIX_LOG  (RADIX_LOG),
            .BIT_WIDTH  (BIT_WIDTH)
        ) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (advance),
            .data_in (data_in),
            .side_in (side_in),
            .data_q  (data_q),
            .side_q  (side_q)
        );
    end

    assign final_data = g_level[LEVELS-1].data_q;
    assign final_side = g_level[LEVELS-1].side_q;
    assign unused_side = ^{final_side.sel, final_side.tag};

`ifdef MUX_TREE_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (advance) begin
            zero_q <= zero_next;
        end
    end

    assign bus.o_zero = zero_q;
`endif

    assign bus.o_ready = advance;
    assign bus.o_valid = final_side.valid;
    assign bus.o_B     = final_data;
    assign bus.o_tag   = final_side.tag[TAG_WIDTH-1:0];
    assign bus.o_oor   = final_side.oor;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: default 81-input build plus a 16-input radix-4 build, scoreboard reference model.
module tb_mux_tree_pipe;
    localparam int BW  = 16;
    localparam int TW  = 8;
    localparam int N_A = 81;
    localparam int N_B = 16;

    typedef struct {
        int            sel;
        logic [TW-1:0] tag;
        logic [BW-1:0] expB;
        logic          expOor;
    } vec_t;

    typedef struct {
        logic [BW-1:0] data;
        logic [TW-1:0] tag;
        logic          oor;
        int            adv;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_tree_pipe_if #(.BIT_WIDTH(BW), .NUM_INPUTS(N_A), .TAG_WIDTH(TW)) ifa ();
    mux_tree_pipe_if #(.BIT_WIDTH(BW), .NUM_INPUTS(N_B), .TAG_WIDTH(TW)) ifb ();

    mux_tree_pipe #(.BIT_WIDTH(BW), .NUM_INPUTS(N_A), .RADIX_LOG(4), .TAG_WIDTH(TW)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    mux_tree_pipe #(.BIT_WIDTH(BW), .NUM_INPUTS(N_B), .RADIX_LOG(2), .TAG_WIDTH(TW)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    int            checkCount = 0;
    int            failCount  = 0;
    item_t         sb[$];
    int            curDut;
    int            curN;
    int            curLevels;
    logic [BW-1:0] memA [N_A];
    logic [BW-1:0] memB [N_B];
    logic [BW-1:0] pendB;
    logic [TW-1:0] pendTag;
    logic          pendOor;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [BW-1:0] refData(input int sel);
        if (sel >= curN) return '0;
        return (curDut == 0) ? memA[sel] : memB[sel];
    endfunction

    task automatic loadInputs();
        for (int k = 0; k < N_A; k++) ifa.i_A[k*BW +: BW] = memA[k];
        for (int k = 0; k < N_B; k++) ifb.i_A[k*BW +: BW] = memB[k];
    endtask

    task automatic applyStimulus(input logic valid, input int sel, input logic [TW-1:0] tag,
                                 input logic ready, input logic [BW-1:0] expB, input logic expOor);
        if (curDut == 0) begin
            ifa.i_valid = valid;
            ifa.i_sel   = 7'(sel);
            ifa.i_tag   = tag;
            ifa.i_ready = ready;
        end else begin
            ifb.i_valid = valid;
            ifb.i_sel   = 4'(sel);
            ifb.i_tag   = tag;
            ifb.i_ready = ready;
        end
        pendB   = expB;
        pendTag = tag;
        pendOor = expOor;
    endtask

    task automatic applyModel(input logic valid, input int sel, input logic [TW-1:0] tag, input logic ready);
        applyStimulus(valid, sel, tag, ready, refData(sel), sel >= curN);
    endtask

    // Each accepted item becomes visible after curLevels global advances and leaves on the next advance.
    task automatic stepCycle(output bit accepted);
        logic          outValid, outReady, outOor, inValid, inReady;
        logic [BW-1:0] outB;
        logic [TW-1:0] outTag;
        bit            expValid, expReady;
        item_t         head;
`ifdef MUX_TREE_ZERO_FLAG_EN
        logic          outZero;
`endif
        @(negedge clk);
        if (curDut == 0) begin
            outValid = ifa.o_valid; outReady = ifa.o_ready; outB = ifa.o_B;
            outTag = ifa.o_tag; outOor = ifa.o_oor; inValid = ifa.i_valid; inReady = ifa.i_ready;
`ifdef MUX_TREE_ZERO_FLAG_EN
            outZero = ifa.o_zero;
`endif
        end else begin
            outValid = ifb.o_valid; outReady = ifb.o_ready; outB = ifb.o_B;
            outTag = ifb.o_tag; outOor = ifb.o_oor; inValid = ifb.i_valid; inReady = ifb.i_ready;
`ifdef MUX_TREE_ZERO_FLAG_EN
            outZero = ifb.o_zero;
`endif
        end
        expValid = (sb.size() > 0) && (sb[0].adv == curLevels);
        expReady = inReady || !expValid;
        checkOutput("o_valid", 32'(outValid), 32'(expValid));
        checkOutput("o_ready", 32'(outReady), 32'(expReady));
        if (expValid) begin
            head = sb[0];
            checkOutput("o_B", 32'(outB), 32'(head.data));
            checkOutput("o_tag", 32'(outTag), 32'(head.tag));
            checkOutput("o_oor", 32'(outOor), 32'(head.oor));
`ifdef MUX_TREE_ZERO_FLAG_EN
            checkOutput("o_zero", 32'(outZero), 32'(head.data == '0));
`endif
        end
        accepted = inValid && expReady;
        if (expReady) begin
            if (expValid) void'(sb.pop_front());
            foreach (sb[i]) sb[i].adv = sb[i].adv + 1;
            if (inValid) sb.push_back('{data: pendB, tag: pendTag, oor: pendOor, adv: 1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int cycles);
        bit acc;
        for (int c = 0; c < cycles; c++) begin
            applyStimulus(1'b0, 0, '0, 1'b1, '0, 1'b0);
            stepCycle(acc);
        end
        checkOutput("drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t          vecs[10];
        bit            acc;
        int            idx;
        logic [BW-1:0] heldB;

        vecs[0] = '{0,   8'h11, 16'd1,  1'b0};
        vecs[1] = '{1,   8'h22, 16'd2,  1'b0};
        vecs[2] = '{7,   8'h33, 16'd8,  1'b0};
        vecs[3] = '{15,  8'h44, 16'd16, 1'b0};
        vecs[4] = '{16,  8'h55, 16'd17, 1'b0};
        vecs[5] = '{64,  8'h66, 16'd65, 1'b0};
        vecs[6] = '{80,  8'h77, 16'd81, 1'b0};
        vecs[7] = '{81,  8'h88, 16'd0,  1'b1};
        vecs[8] = '{100, 8'h99, 16'd0,  1'b1};
        vecs[9] = '{127, 8'hAA, 16'd0,  1'b1};

        for (int k = 0; k < N_A; k++) memA[k] = BW'(k + 1);
        for (int k = 0; k < N_B; k++) memB[k] = BW'($urandom);
        memB[3] = '0;
        loadInputs();

        rst_n = 1'b0;
        curDut = 1; curN = N_B; curLevels = 2;
        applyStimulus(1'b0, 0, '0, 1'b0, '0, 1'b0);
        curDut = 0; curN = N_A; curLevels = 2;
        applyStimulus(1'b0, 0, '0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_o_valid", 32'(ifa.o_valid), 32'd0);
        checkOutput("reset_o_B", 32'(ifa.o_B), 32'd0);
        checkOutput("reset_o_tag", 32'(ifa.o_tag), 32'd0);
        checkOutput("reset_o_oor", 32'(ifa.o_oor), 32'd0);
        checkOutput("reset_empty_o_ready", 32'(ifa.o_ready), 32'd1);
        checkOutput("reset_b_o_valid", 32'(ifb.o_valid), 32'd0);
`ifdef MUX_TREE_ZERO_FLAG_EN
        checkOutput("reset_o_zero", 32'(ifa.o_zero), 32'd0);
`endif
        rst_n = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, vecs[i].sel, vecs[i].tag, 1'b1, vecs[i].expB, vecs[i].expOor);
            stepCycle(acc);
        end
        drain(5);

        $display("[TB] back-to-back sweep");
        for (int s = 0; s < N_A; s++) begin
            applyModel(1'b1, s, TW'(s) ^ 8'h3C, 1'b1);
            stepCycle(acc);
        end
        drain(5);

        $display("[TB] stall mid-stream");
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) heldB = ifa.o_B;
            if (c >= 4 && c <= 6) checkOutput("stall_hold_o_B", 32'(ifa.o_B), 32'(heldB));
            if (idx < 5) applyModel(1'b1, 40 + idx, TW'(8'hC0 + idx), !(c >= 3 && c < 6));
            else         applyStimulus(1'b0, 0, '0, 1'b1, '0, 1'b0);
            stepCycle(acc);
            if (acc) idx++;
        end
        checkOutput("stall_accepted", 32'(idx), 32'd5);
        drain(5);

        $display("[TB] reset with transactions in flight");
        applyModel(1'b1, 10, 8'hA1, 1'b1);
        stepCycle(acc);
        applyModel(1'b1, 20, 8'hA2, 1'b1);
        stepCycle(acc);
        applyStimulus(1'b0, 0, '0, 1'b1, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_o_valid", 32'(ifa.o_valid), 32'd0);
        checkOutput("rst_mid_o_B", 32'(ifa.o_B), 32'd0);
        checkOutput("rst_mid_o_tag", 32'(ifa.o_tag), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyModel(1'b1, 30, 8'hB1, 1'b1);
        stepCycle(acc);
        applyModel(1'b1, 31, 8'hB2, 1'b1);
        stepCycle(acc);
        drain(5);

        $display("[TB] zero element select");
        memA[5] = '0;
        loadInputs();
        applyStimulus(1'b1, 5, 8'h5E, 1'b1, 16'd0, 1'b0);
        stepCycle(acc);
        drain(4);
        memA[5] = 16'd6;
        loadInputs();

        $display("[TB] random traffic, 81 inputs");
        for (int c = 0; c < 300; c++) begin
            applyModel($urandom_range(0, 3) != 0, $urandom_range(0, 127), TW'($urandom), $urandom_range(0, 3) != 0);
            stepCycle(acc);
        end
        drain(6);

        $display("[TB] random traffic, 16 inputs radix 4");
        curDut = 1; curN = N_B; curLevels = 2;
        for (int c = 0; c < 200; c++) begin
            applyModel($urandom_range(0, 3) != 0, $urandom_range(0, 15), TW'($urandom), $urandom_range(0, 3) != 0);
            stepCycle(acc);
        end
        drain(6);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
